sdfa_result_decoder: RTL and testbench

SDFA_RESULT_DECODER -- requirements
Module: sdfa_result_decoder

---
 rtl/sdfa_result_decoder_pkg.sv | 21 ++
 rtl/sdfa_result_decoder_label_fifo.sv | 48 ++++
 rtl/sdfa_result_decoder.sv | 161 ++++++++++++++++
 tb/tb_sdfa_result_decoder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdfa_result_decoder_pkg.sv
// Shared definitions for the SDFA result decoder: FSM states, mode encoding
// and the default number of result slots per frame.
package sdfa_pkg;

  localparam int SDFA_NUM_CLASSES = 10;

  localparam logic MODE_SUM   = 1'b0;
  localparam logic MODE_FIRST = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_REPORT  = 2'd2
  } sdfa_state_e;

  // Plain-vector aliases so the state register stays a legacy logic vector.
  localparam logic [1:0] ST_IDLE    = S_IDLE;
  localparam logic [1:0] ST_COLLECT = S_COLLECT;
  localparam logic [1:0] ST_REPORT  = S_REPORT;

endpackage

// File: rtl/sdfa_result_decoder_label_fifo.sv
// Small register-based FIFO holding the expected labels, one per frame.
// Pushes while full and pops while empty are ignored.
module sdfa_label_fifo
  import sdfa_pkg::*;
#(
  parameter int LABEL_W   = 4,
  parameter int LBL_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [LABEL_W-1:0] din,
  output logic [LABEL_W-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(LBL_DEPTH);

  logic [LABEL_W-1:0] mem [LBL_DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               do_push;
  logic               do_pop;

  // The extra pointer bit tells full apart from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sdfa_result_decoder.sv
// Decodes a frame of per-slot spike bits into a class prediction (index sum or
// first-spike index), scores it against an expected-label FIFO and keeps stats.
module sdfa_result_decoder
  import sdfa_pkg::*;
#(
  parameter int NUM_CLASSES = SDFA_NUM_CLASSES,
  parameter int LABEL_W     = 4,
  parameter int SUM_W       = 6,
  parameter int LBL_DEPTH   = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               result_spike,
  input  logic               result_spike_valid,
  input  logic               mode,
  input  logic [LABEL_W-1:0] true_label,
  input  logic               true_label_valid,
  output logic               true_label_ready,
  input  logic               clear,
  output logic               pred_valid,
  output logic [SUM_W-1:0]   pred_label,
  output logic               pred_hit,
  output logic               pred_anom,
  output logic [CNT_W-1:0]   img_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               sticky_short,
  output logic               sticky_underflow
);

  localparam int               SLOT_W    = $clog2(NUM_CLASSES + 1);
  localparam int               CMP_W     = LABEL_W + SUM_W;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CLASSES - 1);
  localparam logic [SUM_W-1:0]  NO_SPIKE  = SUM_W'(NUM_CLASSES);

  logic [1:0]         state;
  logic [SLOT_W-1:0]  slot;
  logic               mode_q;
  logic [SUM_W-1:0]   acc;
  logic [SUM_W-1:0]   first_idx;
  logic [1:0]         spk_cnt;

  logic               fifo_full;
  logic               fifo_empty;
  logic [LABEL_W-1:0] fifo_head;
  logic               push;
  logic               pop;

  logic               start;
  logic               short_frame;
  logic               last_sample;
  logic [SLOT_W-1:0]  cur_slot;
  logic               cur_mode;
  logic [SUM_W-1:0]   acc_next;
  logic [SUM_W-1:0]   first_next;
  logic [1:0]         cnt_next;
  logic [SUM_W-1:0]   label_next;
  logic [LABEL_W-1:0] head_at_report;
  logic               fifo_live_at_report;
  logic               hit_next;
  logic               report;
  logic               miss;

  // Any valid cycle outside COLLECT (IDLE or the REPORT cycle) opens a frame at slot 0.
  always_comb begin
    start       = result_spike_valid && (state != ST_COLLECT);
    short_frame = (state == ST_COLLECT) && !result_spike_valid;
    cur_slot    = start ? '0 : slot;
    cur_mode    = start ? mode : mode_q;
    last_sample = result_spike_valid && (cur_slot == LAST_SLOT);
    acc_next    = start ? '0 : acc;
    first_next  = start ? NO_SPIKE : first_idx;
    cnt_next    = start ? 2'd0 : spk_cnt;
    if (result_spike) begin
      acc_next = acc_next + SUM_W'(cur_slot);
      if (first_next == NO_SPIKE) first_next = SUM_W'(cur_slot);
      if (cnt_next != 2'd2) cnt_next = cnt_next + 2'd1;
    end
    label_next = (cur_mode == MODE_FIRST) ? first_next : acc_next;
  end

  // The hit is registered one cycle early, so it must predict the FIFO head as
  // REPORT will see it, including a label landing in an empty FIFO right now.
  always_comb begin
    push                = true_label_valid && !fifo_full;
    fifo_live_at_report = !fifo_empty || push;
    head_at_report      = fifo_empty ? true_label : fifo_head;
    hit_next            = fifo_live_at_report &&
                          (CMP_W'(label_next) == CMP_W'(head_at_report));
    report              = (state == ST_REPORT);
    pop                 = report && !fifo_empty;
    miss                = report && !fifo_empty && !pred_hit;
  end

  assign true_label_ready = !fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      slot       <= '0;
      mode_q     <= MODE_SUM;
      acc        <= '0;
      first_idx  <= '0;
      spk_cnt    <= '0;
      pred_valid <= 1'b0;
      pred_label <= '0;
      pred_hit   <= 1'b0;
      pred_anom  <= 1'b0;
    end else begin
      pred_valid <= 1'b0;
      if (result_spike_valid) begin
        slot      <= cur_slot + SLOT_W'(1);
        mode_q    <= cur_mode;
        acc       <= acc_next;
        first_idx <= first_next;
        spk_cnt   <= cnt_next;
        if (last_sample) begin
          state      <= ST_REPORT;
          pred_valid <= 1'b1;
          pred_label <= label_next;
          pred_hit   <= hit_next;
          pred_anom  <= (cnt_next != 2'd1);
        end else begin
          state <= ST_COLLECT;
        end
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  // Clear shares the reset path so it wins over any increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      img_cnt          <= '0;
      err_cnt          <= '0;
      sticky_short     <= 1'b0;
      sticky_underflow <= 1'b0;
    end else begin
      if (report && (img_cnt != '1)) img_cnt <= img_cnt + CNT_W'(1);
      if (miss && (err_cnt != '1))   err_cnt <= err_cnt + CNT_W'(1);
      if (short_frame)               sticky_short <= 1'b1;
      if (report && fifo_empty)      sticky_underflow <= 1'b1;
    end
  end

  sdfa_label_fifo #(
    .LABEL_W  (LABEL_W),
    .LBL_DEPTH(LBL_DEPTH)
  ) u_label_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (true_label),
    .head (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_sdfa_result_decoder.sv
// Self-checking bench for sdfa_result_decoder: directed vector table, directed
// corner sequences and randomized frames against a frame-level reference model.
module tb_sdfa_result_decoder;

  localparam int NC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        result_spike = 1'b0;
  logic        result_spike_valid = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  true_label = '0;
  logic        true_label_valid = 1'b0;
  logic        true_label_ready;
  logic        clear = 1'b0;
  logic        pred_valid;
  logic [5:0]  pred_label;
  logic        pred_hit;
  logic        pred_anom;
  logic [15:0] img_cnt;
  logic [15:0] err_cnt;
  logic        sticky_short;
  logic        sticky_underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] m_q[$];
  int         m_img = 0;
  int         m_err = 0;
  bit         m_short = 0;
  bit         m_under = 0;

  typedef struct {
    bit         m;
    logic [9:0] sp;
    logic [3:0] lbl;
    int         exp_label;
    bit         exp_hit;
    bit         exp_anom;
  } vec_t;

  vec_t vecs[8];

  sdfa_result_decoder dut (
    .clk               (clk),
    .rst               (rst),
    .result_spike      (result_spike),
    .result_spike_valid(result_spike_valid),
    .mode              (mode),
    .true_label        (true_label),
    .true_label_valid  (true_label_valid),
    .true_label_ready  (true_label_ready),
    .clear             (clear),
    .pred_valid        (pred_valid),
    .pred_label        (pred_label),
    .pred_hit          (pred_hit),
    .pred_anom         (pred_anom),
    .img_cnt           (img_cnt),
    .err_cnt           (err_cnt),
    .sticky_short      (sticky_short),
    .sticky_underflow  (sticky_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit s, input bit md);
    result_spike_valid = v;
    result_spike       = s;
    mode               = md;
    tick();
  endtask

  task automatic check_status();
    checkOutput("img_cnt", img_cnt, m_img);
    checkOutput("err_cnt", err_cnt, m_err);
    checkOutput("sticky_short", sticky_short, m_short);
    checkOutput("sticky_underflow", sticky_underflow, m_under);
    checkOutput("true_label_ready", true_label_ready, (m_q.size() < 4) ? 1 : 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pred_valid_idle", pred_valid, 0);
    end
  endtask

  task automatic push_label(input logic [3:0] l);
    result_spike_valid = 1'b0;
    true_label         = l;
    true_label_valid   = 1'b1;
    checkOutput("ready_before_push", true_label_ready, (m_q.size() < 4) ? 1 : 0);
    tick();
    true_label_valid = 1'b0;
    if (m_q.size() < 4) m_q.push_back(l);
  endtask

  task automatic clear_stats();
    result_spike_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_img = 0;
    m_err = 0;
    m_short = 0;
    m_under = 0;
  endtask

  task automatic do_reset();
    result_spike_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_q.delete();
    m_img = 0;
    m_err = 0;
    m_short = 0;
    m_under = 0;
  endtask

  // Drives nslots slots; a full frame ends in the REPORT cycle with valid still high,
  // so a following call starts the next frame back-to-back.
  task automatic run_frame(input bit m, input logic [9:0] sp, input int nslots,
                           input int exp_label, input bit exp_hit, input bit exp_anom);
    for (int i = 0; i < nslots; i++) begin
      applyStimulus(1'b1, sp[i], (i == 0) ? m : bit'($urandom_range(0, 1)));
      if (i < NC - 1) checkOutput("pred_valid_in_frame", pred_valid, 0);
    end
    if (nslots < NC) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pred_valid_short", pred_valid, 0);
      m_short = 1;
    end else begin
      checkOutput("pred_valid", pred_valid, 1);
      checkOutput("pred_label", pred_label, exp_label);
      checkOutput("pred_hit", pred_hit, exp_hit);
      checkOutput("pred_anom", pred_anom, exp_anom);
      m_img++;
      if (m_q.size() == 0) begin
        m_under = 1;
      end else begin
        void'(m_q.pop_front());
        if (!exp_hit) m_err++;
      end
    end
  endtask

  // Reference decode straight from the frame's spike vector.
  task automatic model_frame(input bit m, input logic [9:0] sp, input int nslots);
    int sum, first, cnt, lbl;
    bit hit;
    sum = 0;
    first = NC;
    cnt = 0;
    for (int i = 0; i < NC; i++) begin
      if (sp[i]) begin
        sum += i;
        if (first == NC) first = i;
        cnt++;
      end
    end
    lbl = m ? first : sum;
    hit = (m_q.size() > 0) && (int'(m_q[0]) == lbl);
    run_frame(m, sp, nslots, lbl, hit, cnt != 1);
  endtask

  initial begin
    vecs[0] = '{1'b0, 10'b0010000000, 4'd7, 7, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 10'b0000101000, 4'd3, 3, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 10'b0000101000, 4'd3, 8, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 10'b0000000000, 4'd10, 10, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 10'b0000000000, 4'd0, 0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 10'b1111111111, 4'd13, 45, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 10'b1000000000, 4'd9, 9, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 10'b1000000001, 4'd1, 0, 1'b0, 1'b1};

    do_reset();
    checkOutput("reset_pred_valid", pred_valid, 0);
    checkOutput("reset_pred_label", pred_label, 0);
    check_status();

    for (int i = 0; i < 8; i++) begin
      push_label(vecs[i].lbl);
      run_frame(vecs[i].m, vecs[i].sp, NC, vecs[i].exp_label, vecs[i].exp_hit, vecs[i].exp_anom);
      idle(1);
      if (i == 0) begin
        checkOutput("first_img_cnt", img_cnt, 1);
        checkOutput("first_err_cnt", err_cnt, 0);
      end
      check_status();
    end
    checkOutput("table_err_cnt", err_cnt, 3);

    // Short frame leaves the FIFO untouched, then fill to overflow
    clear_stats();
    push_label(4'd1);
    push_label(4'd2);
    model_frame(1'b0, 10'b0000000010, 6);
    idle(1);
    checkOutput("short_sticky", sticky_short, 1);
    check_status();
    push_label(4'd3);
    push_label(4'd4);
    checkOutput("ready_full", true_label_ready, 0);
    push_label(4'd5);
    checkOutput("fifo_depth_model", m_q.size(), 4);
    check_status();

    // Five back-to-back frames, the last one underflows
    clear_stats();
    model_frame(1'b0, 10'b0000000010, NC);
    model_frame(1'b1, 10'b0000000100, NC);
    model_frame(1'b0, 10'b0000001000, NC);
    model_frame(1'b1, 10'b0000010000, NC);
    model_frame(1'b0, 10'b0000100000, NC);
    idle(2);
    checkOutput("underflow_sticky", sticky_underflow, 1);
    checkOutput("underflow_err_cnt", err_cnt, 0);
    checkOutput("underflow_img_cnt", img_cnt, 5);
    check_status();

    // Reset in slot 4 with clear also high
    push_label(4'd6);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, (i == 2), 1'b0);
    rst = 1'b1;
    clear = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    clear = 1'b0;
    m_q.delete();
    m_img = 0;
    m_err = 0;
    m_short = 0;
    m_under = 0;
    idle(12);
    check_status();

    // Clear coincident with a miss REPORT
    push_label(4'd5);
    model_frame(1'b0, 10'b0010000000, NC);
    clear_stats();
    check_status();
    idle(1);
    checkOutput("clear_win_img", img_cnt, 0);
    checkOutput("clear_win_err", err_cnt, 0);

    // Randomized frames
    for (int it = 0; it < 60; it++) begin
      bit         m;
      logic [9:0] sp;
      int         ns;
      bit         b2b;
      m   = bit'($urandom_range(0, 1));
      sp  = 10'($urandom());
      if ($urandom_range(0, 3) == 0) sp = 10'(1 << $urandom_range(0, 9));
      ns  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, NC - 1) : NC;
      b2b = ($urandom_range(0, 2) == 0);
      if (!b2b || !result_spike_valid) begin
        int k;
        int sum, first;
        sum = 0;
        first = NC;
        for (int i = 0; i < NC; i++) if (sp[i]) begin
          sum += i;
          if (first == NC) first = i;
        end
        k = $urandom_range(0, 2);
        for (int j = 0; j < k; j++)
          push_label($urandom_range(0, 1) ? 4'(m ? first : sum) : 4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 9) == 0 && !result_spike_valid) clear_stats();
      model_frame(m, sp, ns);
      if (!b2b) begin
        idle(1);
        check_status();
      end
    end
    idle(2);
    check_status();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
